vram_rect_blitter: RTL

- Writer side of the bitmap VRAM: fills axis-aligned rectangles of one palette index into the single-port sram that the display path reads.
- Takes one rectangle command per valid/ready handshake, clips it to the screen, and emits one sram write per clock in raster order.
- Drives the sram's i_addr/i_write/i_data, with the address computed as y*SCREEN_WIDTH + x, the same mapping the bitmap reader uses.

---
 rtl/vram_rect_blitter_if.sv | 37 +++
 rtl/vram_rect_blitter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/vram_rect_blitter_if.sv
// rtl/vram_rect_blitter_if.sv - command, sram write and status bundle for the rectangle blitter
//
// Purpose: groups the rectangle command handshake, the sram write port and the
// busy/done status into one bundle.
// Ports (modport slave = blitter side, master = command issuer / sram observer):
//   i_cmd_valid, i_x, i_y, i_w, i_h, i_color : command from master
//   o_cmd_ready                               : blitter accepts a command
//   o_addr, o_data, o_write                   : sram write port
//   o_busy, o_done                            : status
`timescale 1ns/1ps
interface vram_rect_blitter_if #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 6
);
    logic                  i_cmd_valid;
    logic                  o_cmd_ready;
    logic [9:0]            i_x;
    logic [8:0]            i_y;
    logic [9:0]            i_w;
    logic [8:0]            i_h;
    logic [DATA_WIDTH-1:0] i_color;
    logic [ADDR_WIDTH-1:0] o_addr;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_write;
    logic                  o_busy;
    logic                  o_done;

    modport slave (
        input  i_cmd_valid, i_x, i_y, i_w, i_h, i_color,
        output o_cmd_ready, o_addr, o_data, o_write, o_busy, o_done
    );

    modport master (
        output i_cmd_valid, i_x, i_y, i_w, i_h, i_color,
        input  o_cmd_ready, o_addr, o_data, o_write, o_busy, o_done
    );
endinterface

// File: rtl/vram_rect_blitter.sv
// rtl/vram_rect_blitter.sv - clipped rectangle fill into the bitmap vram, one write per clock
//
// Purpose: accepts one rectangle command per handshake, clips it to the screen
// and writes the palette index to every covered pixel in raster order, using
// address = y*SCREEN_WIDTH + x.
// Ports:
//   i_clk : system clock, rising edge
//   i_rst : synchronous active-high reset
//   bus   : vram_rect_blitter_if.slave (command in, sram write out, busy/done)
`timescale 1ns/1ps
module vram_rect_blitter #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int ADDR_WIDTH    = 19,
    parameter int DATA_WIDTH    = 6
) (
    input  logic i_clk,
    input  logic i_rst,
    vram_rect_blitter_if.slave bus
);
    localparam logic [10:0]           W11 = 11'(SCREEN_WIDTH);
    localparam logic [9:0]            W10 = 10'(SCREEN_WIDTH);
    localparam logic [9:0]            H10 = 10'(SCREEN_HEIGHT);
    localparam logic [8:0]            H9  = 9'(SCREEN_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] W_A = ADDR_WIDTH'(SCREEN_WIDTH);

    typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;
    state_t state;

    logic [9:0]            x_q, w_q, col, ew_m1;
    logic [8:0]            y_q, h_q, row, eh_m1;
    logic [DATA_WIDTH-1:0] color_q;
    logic [ADDR_WIDTH-1:0] row_base;

    logic                  ready_q, busy_q, done_q, write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;

    // Clip arithmetic uses one extra bit so x+w / y+h cannot overflow.
    logic [10:0]           x_end;
    logic [9:0]            y_end;
    logic                  is_empty;
    logic [9:0]            ew;
    logic [8:0]            eh;
    logic [ADDR_WIDTH-1:0] start_addr;

    always_comb begin
        x_end      = {1'b0, x_q} + {1'b0, w_q};
        y_end      = {1'b0, y_q} + {1'b0, h_q};
        is_empty   = ({1'b0, x_q} >= W11) || ({1'b0, y_q} >= H10) ||
                     (w_q == 10'd0) || (h_q == 9'd0);
        // Only meaningful when not empty, so x < width and y < height here.
        ew         = (x_end > W11) ? (W10 - x_q) : w_q;
        eh         = (y_end > H10) ? (H9 - y_q) : h_q;
        start_addr = ADDR_WIDTH'(y_q) * W_A + ADDR_WIDTH'(x_q);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            w_q      <= '0;
            h_q      <= '0;
            color_q  <= '0;
            col      <= '0;
            row      <= '0;
            ew_m1    <= '0;
            eh_m1    <= '0;
            row_base <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ready_q <= 1'b1;
                    // ready_q is registered, so the first cycle after reset
                    // release cannot accept before ready is visible.
                    if (bus.i_cmd_valid && ready_q) begin
                        x_q     <= bus.i_x;
                        y_q     <= bus.i_y;
                        w_q     <= bus.i_w;
                        h_q     <= bus.i_h;
                        color_q <= bus.i_color;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (is_empty) begin
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        ew_m1    <= ew - 10'd1;
                        eh_m1    <= eh - 9'd1;
                        col      <= '0;
                        row      <= '0;
                        row_base <= start_addr;
                        // Outputs are registered: present the first write now
                        // so it appears on the first FILL cycle.
                        write_q  <= 1'b1;
                        addr_q   <= start_addr;
                        data_q   <= color_q;
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (col == ew_m1) begin
                        if (row == eh_m1) begin
                            write_q <= 1'b0;
                            done_q  <= 1'b1;
                            state   <= DONE;
                        end else begin
                            col      <= '0;
                            row      <= row + 9'd1;
                            row_base <= row_base + W_A;
                            addr_q   <= row_base + W_A;
                        end
                    end else begin
                        col    <= col + 10'd1;
                        addr_q <= addr_q + ADDR_WIDTH'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_cmd_ready = ready_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_done      = done_q;
    assign bus.o_write     = write_q;
    assign bus.o_addr      = addr_q;
    assign bus.o_data      = data_q;
endmodule
